hc595_display_monitor: RTL and testbench
========================================

// Module: hc595_display_monitor
// PURPOSE
//  Receive-side model of the 74HC595 seven-segment serial link: watches rclk/sclk/sdio,
//  rebuilds each 16-bit frame, and decodes it back into per-digit 5-bit display codes.
//  Used as a loopback checker: the display driver's outputs feed this block, and its
//  digit outputs are compared against the calculator's intended display contents.
// PARAMETERS
//  SYNC_STAGES  2   synchronizer flops on sclk_in/sdio_in/rclk_in (legal range 2..4)
//  FRAME_BITS   16  sclk rising edges expected per rclk frame
// PORTS
//  clk          in   1   system clock (12 MHz)
//  rst_n        in   1   asynchronous active-low reset
//  sclk_in      in   1   595 SCK; data is sampled on its rising edge
//  sdio_in      in   1   595 SER serial data, MSB first
//  rclk_in      in   1   595 RCK; a rising edge latches the frame
//  digit_codes  out  40  8 x 5-bit codes; [4:0]=digit1 ... [39:35]=digit8
//  dot_en       out  8   decimal point per digit; bit0=digit1
//  frame_valid  out  1   1-clk pulse when a good frame updates one digit
//  frame_err    out  1   1-clk pulse when a frame is rejected
//  refresh_done out  1   1-clk pulse when all 8 digits have updated since the last pulse
// BEHAVIOUR
//  Reset (async): digit_codes all 5'd16 (blank); dot_en=0; all pulses 0; shift reg=0;
//   bit_cnt=0; seen mask=0; synchronizers=0.
//  Inputs pass through SYNC_STAGES flops. Edges are detected on the last stage vs one
//   extra flop. sdio uses the same depth, so it stays aligned with sclk.
//  Minimum input timing: sclk high and low >= 2 clk each; sdio stable 1 clk around rise.
//  sclk rise: shift_reg <= {shift_reg[14:0], sdio}; bit_cnt saturates at FRAME_BITS+1.
//  rclk rise: evaluate the frame using bit_cnt/shift_reg *including* any sclk shift in
//   the same cycle. Then bit_cnt <= 0.
//  Frame format: [15:8] segment byte, active-low {dp,g,f,e,d,c,b,a};
//   [7:0] digit select, active-low one-hot; bit0 = digit1.
//  Frame good when bit_cnt==FRAME_BITS AND exactly one select bit is low.
//   Otherwise: frame_err pulse; no output change.
//  Good frame, selected digit k:
//   digit_codes[k] <= decode(seg[6:0]); dot_en[k] <= ~seg[7]; frame_valid pulses.
//   Outputs and pulse are registered in the cycle after the detected rclk edge.
//   Total latency from the rclk_in pin rise to the output: SYNC_STAGES+2 clk.
//  Decode table (segment byte [6:0] active-low, g..a) -> code:
//   0:C0->0  1:F9->1  2:A4->2  3:B0->3  4:99->4  5:92->5  6:82->6  7:F8->7
//   8:80->8  9:90->9  '-':BF->12  'E':86->15  blank:FF->16  'r':AF->17
//   Any other pattern -> 5'd31 (still a good frame, no frame_err).
//  Seen mask: set bit k on each good frame. When the mask becomes 8'hFF, refresh_done
//   pulses in the same cycle as frame_valid and the mask clears.
//  A repeated digit before all 8 are seen is allowed; the digit simply updates again.
//  rclk with bit_cnt==0 (no sclk since last latch): frame_err.
//  Reset mid-frame: partial shift data is discarded; outputs return to blank immediately.
// TESTING
//  1 Send frame {C0, FE} (16 clocks, rclk) -> digit1=0, dot1=0, one frame_valid pulse,
//    no frame_err.
//  2 Scan digits 1..8 with patterns 1..8, digit8 dp on (seg 0x00, sel 7F)
//    -> codes 1..8, dot_en=80, refresh_done with the 8th frame_valid only.
//  3 15-bit frame, then 17-bit frame, then sel=FC (two digits)
//    -> three frame_err pulses, outputs unchanged.
//  4 Pattern BF / 86 / AF / FF / 0x55 on digit3 -> codes 12 / 15 / 17 / 16 / 31.
//  5 sclk 16th rise and rclk rise in the same synchronized cycle -> frame accepted,
//    LSB included.
//  6 Assert rst_n low after 9 bits of a frame, release, send a full frame
//    -> blank after reset; new frame decodes correctly.

Source files
------------

// File: rtl/hc595_display_monitor_if.sv
// hc595_display_monitor_if
//   Connects the 74HC595 serial link to the display monitor. The link side
//   (master) drives the three 595 pins. The monitor side (slave) returns the
//   decoded digits and the status pulses.
//   sclk          595 SCK, data sampled on its rising edge
//   sdio          595 SER serial data, MSB first
//   rclk          595 RCK, a rising edge latches the frame
//   digit_codes   8 x 5-bit codes, [4:0]=digit1 ... [39:35]=digit8
//   dot_en        decimal point per digit, bit0=digit1
//   frame_valid   1-clk pulse when a good frame updates one digit
//   frame_err     1-clk pulse when a frame is rejected
//   refresh_done  1-clk pulse when all 8 digits have updated since the last pulse
interface hc595_display_monitor_if;
  logic        sclk;
  logic        sdio;
  logic        rclk;
  logic [39:0] digit_codes;
  logic [7:0]  dot_en;
  logic        frame_valid;
  logic        frame_err;
  logic        refresh_done;

  modport master (
    output sclk, sdio, rclk,
    input  digit_codes, dot_en, frame_valid, frame_err, refresh_done
  );

  modport slave (
    input  sclk, sdio, rclk,
    output digit_codes, dot_en, frame_valid, frame_err, refresh_done
  );
endinterface

// File: rtl/hc595_display_monitor.sv
// hc595_display_monitor
//   Receive-side model of the 74HC595 seven-segment link. It rebuilds each
//   16-bit frame from sclk/sdio, checks the frame on the rclk rise, and decodes
//   the segment byte back into a 5-bit display code for the selected digit.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   mon    slave modport: 595 pins in, decoded digits and status pulses out
module hc595_display_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  hc595_display_monitor_if.slave    mon
);

  localparam int                CNT_W    = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_BITS);

  logic [SYNC_STAGES-1:0] sclk_sync, sdio_sync, rclk_sync;
  logic                   sclk_last, rclk_last;
  logic                   sclk_rise, rclk_rise, sdio_s;

  logic [15:0]      shift_reg, shift_nxt;
  logic [CNT_W-1:0] bit_cnt, cnt_nxt;
  logic [7:0]       sel_low;
  logic             one_low, frame_good;

  logic             pend_vld, pend_good;
  logic [15:0]      pend_frame;

  logic [39:0]      codes;
  logic [7:0]       dots;
  logic [7:0]       seen, seen_nxt;
  logic             valid_q, err_q, refresh_q;

  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    case (seg)
      7'h40:   decode_seg = 5'd0;
      7'h79:   decode_seg = 5'd1;
      7'h24:   decode_seg = 5'd2;
      7'h30:   decode_seg = 5'd3;
      7'h19:   decode_seg = 5'd4;
      7'h12:   decode_seg = 5'd5;
      7'h02:   decode_seg = 5'd6;
      7'h78:   decode_seg = 5'd7;
      7'h00:   decode_seg = 5'd8;
      7'h10:   decode_seg = 5'd9;
      7'h3F:   decode_seg = 5'd12;
      7'h06:   decode_seg = 5'd15;
      7'h7F:   decode_seg = 5'd16;
      7'h2F:   decode_seg = 5'd17;
      default: decode_seg = 5'd31;
    endcase
  endfunction

  // sdio runs through the same depth as sclk so the sampled bit stays aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      sdio_sync <= '0;
      rclk_sync <= '0;
      sclk_last <= 1'b0;
      rclk_last <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], mon.sclk};
      sdio_sync <= {sdio_sync[SYNC_STAGES-2:0], mon.sdio};
      rclk_sync <= {rclk_sync[SYNC_STAGES-2:0], mon.rclk};
      sclk_last <= sclk_sync[SYNC_STAGES-1];
      rclk_last <= rclk_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_last;
  assign rclk_rise = rclk_sync[SYNC_STAGES-1] & ~rclk_last;
  assign sdio_s    = sdio_sync[SYNC_STAGES-1];

  // The frame check uses the post-shift view so an sclk rise coinciding with
  // the rclk rise still contributes its bit.
  always_comb begin
    shift_nxt = shift_reg;
    cnt_nxt   = bit_cnt;
    if (sclk_rise) begin
      shift_nxt = {shift_reg[14:0], sdio_s};
      if (bit_cnt != CNT_MAX) cnt_nxt = bit_cnt + 1'b1;
    end
    sel_low    = ~shift_nxt[7:0];
    one_low    = (sel_low != 8'd0) && ((sel_low & (sel_low - 8'd1)) == 8'd0);
    frame_good = (cnt_nxt == CNT_FULL) && one_low;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg  <= '0;
      bit_cnt    <= '0;
      pend_vld   <= 1'b0;
      pend_good  <= 1'b0;
      pend_frame <= '0;
    end else begin
      shift_reg <= shift_nxt;
      bit_cnt   <= rclk_rise ? '0 : cnt_nxt;
      pend_vld  <= rclk_rise;
      if (rclk_rise) begin
        pend_good  <= frame_good;
        pend_frame <= shift_nxt;
      end
    end
  end

  assign seen_nxt = seen | ~pend_frame[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      codes     <= {8{5'd16}};
      dots      <= '0;
      seen      <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      refresh_q <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      refresh_q <= 1'b0;
      if (pend_vld) begin
        if (pend_good) begin
          for (int i = 0; i < 8; i++) begin
            if (!pend_frame[i]) begin
              codes[i*5 +: 5] <= decode_seg(pend_frame[14:8]);
              dots[i]         <= ~pend_frame[15];
            end
          end
          valid_q <= 1'b1;
          if (seen_nxt == 8'hFF) begin
            refresh_q <= 1'b1;
            seen      <= '0;
          end else begin
            seen <= seen_nxt;
          end
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign mon.digit_codes  = codes;
  assign mon.dot_en       = dots;
  assign mon.frame_valid  = valid_q;
  assign mon.frame_err    = err_q;
  assign mon.refresh_done = refresh_q;

endmodule

// File: tb/tb_hc595_display_monitor.sv
// tb_hc595_display_monitor
//   Drives 595-style frames into hc595_display_monitor and compares the decoded
//   display against a behavioural model of the display contents.
module tb_hc595_display_monitor;

  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hc595_display_monitor_if bus ();

  hc595_display_monitor #(.SYNC_STAGES(2), .FRAME_BITS(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mon   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // pulse counters observed on the falling edge
  int n_fv = 0, n_fe = 0, n_rd = 0, n_rd_orphan = 0;
  always @(negedge clk) begin
    if (bus.frame_valid === 1'b1) n_fv++;
    if (bus.frame_err === 1'b1) n_fe++;
    if (bus.refresh_done === 1'b1) begin
      n_rd++;
      if (bus.frame_valid !== 1'b1) n_rd_orphan++;
    end
  end

  // behavioural model of what the display should show
  logic [4:0] m_code [8];
  logic [7:0] m_dot;
  bit         m_seen [8];
  int         e_fv = 0, e_fe = 0, e_rd = 0;

  logic [7:0] pat_tab  [14] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82,
                                8'hF8, 8'h80, 8'h90, 8'hBF, 8'h86, 8'hFF, 8'hAF};
  logic [4:0] code_tab [14] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6,
                                5'd7, 5'd8, 5'd9, 5'd12, 5'd15, 5'd16, 5'd17};

  function automatic logic [4:0] ref_decode(input logic [7:0] seg);
    ref_decode = 5'd31;
    for (int i = 0; i < 14; i++)
      if (pat_tab[i][6:0] == seg[6:0]) ref_decode = code_tab[i];
  endfunction

  function automatic logic [39:0] m_packed();
    logic [39:0] p;
    for (int i = 0; i < 8; i++) p[i*5 +: 5] = m_code[i];
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_code[i] = 5'd16;
      m_seen[i] = 1'b0;
    end
    m_dot = 8'h00;
  endtask

  task automatic model_frame(input logic [15:0] f, input int nbits);
    int zeros, k;
    bit all;
    zeros = 0;
    k = 0;
    for (int i = 0; i < 8; i++)
      if (f[i] == 1'b0) begin
        zeros++;
        k = i;
      end
    if (nbits == 16 && zeros == 1) begin
      m_code[k] = ref_decode(f[15:8]);
      m_dot[k]  = ~f[15];
      m_seen[k] = 1'b1;
      e_fv++;
      all = 1'b1;
      for (int i = 0; i < 8; i++) all = all & m_seen[i];
      if (all) begin
        e_rd++;
        for (int i = 0; i < 8; i++) m_seen[i] = 1'b0;
      end
    end else begin
      e_fe++;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".codes"}, 64'(bus.digit_codes), 64'(m_packed()));
    check({tag, ".dots"}, 64'(bus.dot_en), 64'(m_dot));
    check({tag, ".n_valid"}, 64'(n_fv), 64'(e_fv));
    check({tag, ".n_err"}, 64'(n_fe), 64'(e_fe));
    check({tag, ".n_refresh"}, 64'(n_rd), 64'(e_rd));
    check({tag, ".orphan_refresh"}, 64'(n_rd_orphan), 64'd0);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // shifts data[nbits-1] down to data[0]; with hold_last the final bit is only
  // placed on sdio, leaving its sclk rise to the caller
  task automatic shift_bits(input logic [31:0] data, input int nbits, input bit hold_last);
    for (int i = nbits - 1; i >= 0; i--) begin
      bus.sdio = data[i];
      wait_neg(2);
      if (hold_last && i == 0) break;
      bus.sclk = 1'b1;
      wait_neg(2);
      bus.sclk = 1'b0;
      wait_neg(1);
    end
  endtask

  // raises rclk (and sclk when both_rise) and counts clocks to the status pulse
  task automatic latch_measure(input bit both_rise, output int lat);
    lat = -1;
    bus.rclk = 1'b1;
    if (both_rise) bus.sclk = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 3) begin
        bus.rclk = 1'b0;
        bus.sclk = 1'b0;
      end
      if (lat < 0 && (bus.frame_valid === 1'b1 || bus.frame_err === 1'b1)) lat = c;
    end
    wait_neg(2);
  endtask

  task automatic send_frame(input string tag, input logic [31:0] data, input int nbits,
                            input bit both_rise);
    int lat;
    if (nbits > 0) shift_bits(data, nbits, both_rise);
    latch_measure(both_rise, lat);
    model_frame(data[15:0], nbits);
    check({tag, ".latency"}, 64'(lat), 64'(LAT));
    check_all(tag);
  endtask

  logic [7:0] t2_seg [8] = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h00};
  logic [7:0] t4_seg [5] = '{8'hBF, 8'h86, 8'hAF, 8'hFF, 8'h55};
  logic [4:0] t4_exp [5] = '{5'd12, 5'd15, 5'd17, 5'd16, 5'd31};

  initial begin
    logic [7:0] seg, sel;
    int nb, r;

    bus.sclk = 1'b0;
    bus.sdio = 1'b0;
    bus.rclk = 1'b0;
    model_reset();
    wait_neg(3);
    check_all("reset");
    check("reset.frame_valid", 64'(bus.frame_valid), 64'd0);
    check("reset.frame_err", 64'(bus.frame_err), 64'd0);
    rst_n = 1'b1;
    wait_neg(3);

    // single frame on digit1
    send_frame("t1", {16'h0, 8'hC0, 8'hFE}, 16, 1'b0);
    check("t1.digit1", 64'(bus.digit_codes[4:0]), 64'd0);

    // scan all eight digits
    for (int i = 0; i < 8; i++) begin
      sel = ~(8'h01 << i);
      send_frame($sformatf("t2.d%0d", i + 1), {16'h0, t2_seg[i], sel}, 16, 1'b0);
    end
    check("t2.dot_en", 64'(bus.dot_en), 64'h80);

    // rejected frames
    send_frame("t3.short", {16'h0, 8'hC0, 8'hFE}, 15, 1'b0);
    send_frame("t3.long", {15'h0, 1'b1, 8'hC0, 8'hFE}, 17, 1'b0);
    send_frame("t3.twosel", {16'h0, 8'hC0, 8'hFC}, 16, 1'b0);
    send_frame("t3.nobits", 32'h0, 0, 1'b0);

    // special patterns on digit3
    for (int i = 0; i < 5; i++) begin
      send_frame($sformatf("t4.p%0d", i), {16'h0, t4_seg[i], 8'hFB}, 16, 1'b0);
      check($sformatf("t4.code%0d", i), 64'(bus.digit_codes[14:10]), 64'(t4_exp[i]));
    end

    // last sclk rise coincides with rclk rise; the LSB selects digit5
    send_frame("t5", {16'h0, 8'h99, 8'hEF}, 16, 1'b1);
    check("t5.digit5", 64'(bus.digit_codes[24:20]), 64'd4);

    // reset in the middle of a frame
    shift_bits({16'h0, 8'h82, 8'hFD}, 9, 1'b0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("t6.blank_codes", 64'(bus.digit_codes), 64'(m_packed()));
    check("t6.blank_dots", 64'(bus.dot_en), 64'd0);
    wait_neg(2);
    rst_n = 1'b1;
    wait_neg(3);
    send_frame("t6.after", {16'h0, 8'hA4, 8'hBF}, 16, 1'b0);
    check("t6.digit7", 64'(bus.digit_codes[34:30]), 64'd2);

    // randomized frames
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 99));
      seg = (r < 70) ? pat_tab[$urandom_range(0, 13)] : 8'($urandom);
      if ($urandom_range(0, 99) < 50) seg[7] = ~seg[7];
      sel = ($urandom_range(0, 99) < 80) ? ~(8'h01 << $urandom_range(0, 7)) : 8'($urandom);
      r = int'($urandom_range(0, 99));
      nb = (r < 85) ? 16 : ((r < 92) ? 15 : 17);
      send_frame($sformatf("rnd%0d", n), {15'($urandom), 1'b1, seg, sel}, nb,
                 ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
